// File: rtl/output_buffer_if.sv
// Sink stream and parallel source buses of output_buffer.
// Sink: an entry transfers on a sink_clk edge with sink_valid && sink_ready. Source: no backpressure, source_valid qualifies each word.
interface output_buffer_if #(
    parameter int NSOURCE = 4,
    parameter int WIDTH   = 16
);
    logic                    sink_valid;
    logic                    sink_sop;
    logic                    sink_eop;
    logic signed [WIDTH-1:0] sink_data;
    logic                    sink_ready;
    logic                    sink_error;
    logic                    source_start;
    logic                    source_valid;
    logic                    source_sop;
    logic                    source_eop;
    logic signed [WIDTH-1:0] source_data [NSOURCE];

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_data,
        input  sink_ready, sink_error,
        input  source_start, source_valid, source_sop, source_eop, source_data
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_data,
        output sink_ready, sink_error,
        output source_start, source_valid, source_sop, source_eop, source_data
    );
endinterface

// File: rtl/output_buffer.sv
// Serial-in/parallel-out buffer: NSOURCE batches written on sink_clk, replayed in parallel on source_clk.
// Optional sop/eop framing checks in BUSY are enabled by defining OUTPUT_BUFFER_FRAMING_EN.
module output_buffer #(
    parameter int NSOURCE = 4,
    parameter int WIDTH   = 16,
    parameter int LENGTH  = 8
) (
    input  logic           sink_clk,
    input  logic           source_clk,
    input  logic           reset,
    output_buffer_if.slave bus,
    output logic [1:0]     dbg_sink_state_o,
    output logic [1:0]     dbg_source_state_o
);
    localparam int AWIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int BWIDTH = (NSOURCE > 1) ? $clog2(NSOURCE) : 1;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(LENGTH - 1);
    localparam logic [BWIDTH-1:0] LAST_BANK = BWIDTH'(NSOURCE - 1);

    typedef enum logic [1:0] {SNK_IDLE = 2'd0, SNK_BUSY = 2'd1, SNK_DONE = 2'd2} snk_state_e;
    typedef enum logic [1:0] {SRC_IDLE = 2'd0, SRC_BUSY = 2'd1, SRC_ACK = 2'd2} src_state_e;

    logic signed [WIDTH-1:0] ram [NSOURCE][LENGTH];

    snk_state_e        snk_state_q;
    logic [AWIDTH-1:0] wraddr_q;
    logic [BWIDTH-1:0] bank_q;
    logic              done_q, ready_q, error_q;
    logic              ack_meta_q, ack_sync_q;

    src_state_e        src_state_q;
    logic [AWIDTH-1:0] rdaddr_q;
    logic              start_q, ack_q;
    logic              done_meta_q, done_sync_q;
    logic              rst_meta_q, rst_sync_q;
    logic [2:0]        pipe1_q, pipe2_q;
    logic signed [WIDTH-1:0] rd1_q [NSOURCE];
    logic signed [WIDTH-1:0] rd2_q [NSOURCE];

    logic              accept, restart, frame_err, wr_en, wr_last_addr, wr_last;
    logic [AWIDTH-1:0] wr_addr;
    logic [BWIDTH-1:0] wr_bank;

    always_comb begin
        accept = bus.sink_valid && ready_q &&
                 (snk_state_q == SNK_BUSY || (snk_state_q == SNK_IDLE && bus.sink_sop));
`ifdef OUTPUT_BUFFER_FRAMING_EN
        restart   = accept && snk_state_q == SNK_BUSY && bus.sink_sop && wraddr_q != '0;
        frame_err = accept && snk_state_q == SNK_BUSY && !restart &&
                    (bus.sink_eop != (wraddr_q == LAST_ADDR));
`else
        restart   = 1'b0;
        frame_err = 1'b0;
`endif
        wr_en        = accept && !frame_err;
        wr_addr      = (snk_state_q == SNK_IDLE || restart) ? '0 : wraddr_q;
        wr_bank      = (snk_state_q == SNK_IDLE || restart) ? '0 : bank_q;
        wr_last_addr = (wr_addr == LAST_ADDR);
        wr_last      = wr_last_addr && (wr_bank == LAST_BANK);
    end

`ifndef OUTPUT_BUFFER_FRAMING_EN
    logic framing_unused;
    assign framing_unused = bus.sink_eop;
`endif

    always_ff @(posedge sink_clk) begin
        if (wr_en) ram[wr_bank][wr_addr] <= bus.sink_data;
    end

    // done is only raised once the previous ack has dropped, so a stale ack never ends a new run.
    always_ff @(posedge sink_clk) begin
        if (reset) begin
            snk_state_q <= SNK_IDLE;
            wraddr_q    <= '0;
            bank_q      <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_sync_q  <= 1'b0;
        end else begin
            ack_meta_q <= ack_q;
            ack_sync_q <= ack_meta_q;
            error_q    <= 1'b0;
            case (snk_state_q)
                SNK_IDLE, SNK_BUSY: begin
                    ready_q <= 1'b1;
                    error_q <= restart || frame_err;
                    if (frame_err) begin
                        snk_state_q <= SNK_IDLE;
                        wraddr_q    <= '0;
                        bank_q      <= '0;
                    end else if (wr_en) begin
                        if (wr_last) begin
                            snk_state_q <= SNK_DONE;
                            ready_q     <= 1'b0;
                            done_q      <= !ack_sync_q;
                            wraddr_q    <= '0;
                            bank_q      <= '0;
                        end else if (wr_last_addr) begin
                            snk_state_q <= SNK_BUSY;
                            wraddr_q    <= '0;
                            bank_q      <= wr_bank + BWIDTH'(1);
                        end else begin
                            snk_state_q <= SNK_BUSY;
                            wraddr_q    <= wr_addr + AWIDTH'(1);
                            bank_q      <= wr_bank;
                        end
                    end
                end
                SNK_DONE: begin
                    error_q <= bus.sink_valid;
                    if (done_q && ack_sync_q) begin
                        done_q      <= 1'b0;
                        ready_q     <= 1'b1;
                        snk_state_q <= SNK_IDLE;
                    end else if (!ack_sync_q) begin
                        done_q <= 1'b1;
                    end
                end
                default: snk_state_q <= SNK_IDLE;
            endcase
        end
    end

    always_ff @(posedge source_clk) begin
        rst_meta_q <= reset;
        rst_sync_q <= rst_meta_q;
    end

    always_ff @(posedge source_clk) begin
        if (rst_sync_q) begin
            src_state_q <= SRC_IDLE;
            rdaddr_q    <= '0;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
        end else begin
            done_meta_q <= done_q;
            done_sync_q <= done_meta_q;
            start_q     <= 1'b0;
            case (src_state_q)
                SRC_IDLE: if (done_sync_q) begin
                    start_q     <= 1'b1;
                    rdaddr_q    <= '0;
                    src_state_q <= SRC_BUSY;
                end
                SRC_BUSY: if (rdaddr_q == LAST_ADDR) begin
                    ack_q       <= 1'b1;
                    src_state_q <= SRC_ACK;
                end else begin
                    rdaddr_q <= rdaddr_q + AWIDTH'(1);
                end
                SRC_ACK: if (!done_sync_q) begin
                    ack_q       <= 1'b0;
                    src_state_q <= SRC_IDLE;
                end
                default: src_state_q <= SRC_IDLE;
            endcase
        end
    end

    always_ff @(posedge source_clk) begin
        for (int i = 0; i < NSOURCE; i++) begin
            rd1_q[i] <= ram[i][rdaddr_q];
            rd2_q[i] <= rd1_q[i];
        end
    end

    // Flags {valid, sop, eop} travel alongside the two RAM read stages into the output registers.
    always_ff @(posedge source_clk) begin
        if (rst_sync_q) begin
            pipe1_q          <= '0;
            pipe2_q          <= '0;
            bus.source_valid <= 1'b0;
            bus.source_sop   <= 1'b0;
            bus.source_eop   <= 1'b0;
            for (int i = 0; i < NSOURCE; i++) bus.source_data[i] <= '0;
        end else begin
            pipe1_q          <= {src_state_q == SRC_BUSY, rdaddr_q == '0, rdaddr_q == LAST_ADDR};
            pipe2_q          <= pipe1_q;
            bus.source_valid <= pipe2_q[2];
            bus.source_sop   <= pipe2_q[2] && pipe2_q[1];
            bus.source_eop   <= pipe2_q[2] && pipe2_q[0];
            for (int i = 0; i < NSOURCE; i++) bus.source_data[i] <= rd2_q[i];
        end
    end

    assign bus.sink_ready      = ready_q;
    assign bus.sink_error      = error_q;
    assign bus.source_start    = start_q;
    assign dbg_sink_state_o    = snk_state_q;
    assign dbg_source_state_o  = src_state_q;
endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: table of full runs plus hand sequences for reset, back-to-back and framing cases.
`timescale 1ns/1ps
module tb_output_buffer;
    localparam int NSOURCE = 4;
    localparam int WIDTH   = 16;
    localparam int LENGTH  = 8;
    localparam int CW      = 2 + NSOURCE * WIDTH;

    logic       sink_clk = 1'b0;
    logic       source_clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_snk, dbg_src;

    output_buffer_if #(.NSOURCE(NSOURCE), .WIDTH(WIDTH)) bus();

    output_buffer #(.NSOURCE(NSOURCE), .WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .sink_clk          (sink_clk),
        .source_clk        (source_clk),
        .reset             (reset),
        .bus               (bus),
        .dbg_sink_state_o  (dbg_snk),
        .dbg_source_state_o(dbg_src)
    );

    initial forever #5 sink_clk = ~sink_clk;
    initial forever #6.85 source_clk = ~source_clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int start_cnt = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] cap_q[$];

    typedef struct {
        string            name;
        logic [WIDTH-1:0] base;
        int               extra;
        int               exp_err;
    } run_vec_t;
    run_vec_t vecs[4];

    function automatic logic [CW-1:0] pack_out();
        logic [CW-1:0] w;
        w = '0;
        w[CW-1] = bus.source_sop;
        w[CW-2] = bus.source_eop;
        for (int i = 0; i < NSOURCE; i++) w[(NSOURCE-1-i)*WIDTH +: WIDTH] = bus.source_data[i];
        return w;
    endfunction

    always @(negedge sink_clk) if (!reset && bus.sink_error) err_cnt++;

    always @(negedge source_clk) begin
        if (bus.source_start) start_cnt++;
        if (bus.source_valid) cap_q.push_back(pack_out());
    end

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word k of a run replays source_data[i] = base + LENGTH*i + k.
    task automatic push_run(input logic [WIDTH-1:0] base);
        logic [CW-1:0] w;
        for (int k = 0; k < LENGTH; k++) begin
            w = '0;
            w[CW-1] = (k == 0);
            w[CW-2] = (k == LENGTH - 1);
            for (int i = 0; i < NSOURCE; i++)
                w[(NSOURCE-1-i)*WIDTH +: WIDTH] = base + WIDTH'(i * LENGTH + k);
            exp_q.push_back(w);
        end
    endtask

    task automatic send_entry(input logic [WIDTH-1:0] d, input logic sop, input logic eop);
        bus.sink_valid = 1'b1;
        bus.sink_sop   = sop;
        bus.sink_eop   = eop;
        bus.sink_data  = d;
        @(posedge sink_clk);
        #1;
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
    endtask

    task automatic send_run(input logic [WIDTH-1:0] base, input bit marks);
        for (int b = 0; b < NSOURCE; b++)
            for (int k = 0; k < LENGTH; k++)
                send_entry(base + WIDTH'(b * LENGTH + k),
                           marks ? (k == 0) : (b == 0 && k == 0),
                           marks && (k == LENGTH - 1));
    endtask

    task automatic wait_ready(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge sink_clk);
            seen = bus.sink_ready;
        end
        check(name, CW'(seen), CW'(1));
    endtask

    task automatic wait_burst(input int n);
        for (int i = 0; i < 400 && cap_q.size() < n; i++) @(negedge source_clk);
        repeat (6) @(negedge source_clk);
    endtask

    task automatic check_out(input string name);
        check({name, "_words"}, CW'(cap_q.size()), CW'(exp_q.size()));
        while (cap_q.size() > 0 && exp_q.size() > 0) check({name, "_word"}, cap_q.pop_front(), exp_q.pop_front());
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_counts();
        err_cnt   = 0;
        start_cnt = 0;
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bus.sink_valid = 1'b0;
        bus.sink_sop   = 1'b0;
        bus.sink_eop   = 1'b0;
        bus.sink_data  = '0;
        vecs[0] = '{"s1_ramp",   16'h0000, 0, 0};
        vecs[1] = '{"s2_extra",  16'h0000, 5, 5};
        vecs[2] = '{"neg_ramp",  16'hFFEC, 0, 0};
        vecs[3] = '{"wrap_ramp", 16'h7FF0, 2, 2};

        repeat (8) @(posedge sink_clk);
        @(negedge sink_clk);
        check("rst_ready", CW'(bus.sink_ready), CW'(0));
        check("rst_error", CW'(bus.sink_error), CW'(0));
        check("rst_start", CW'(bus.source_start), CW'(0));
        check("rst_valid", CW'(bus.source_valid), CW'(0));
        check("rst_out", pack_out(), '0);
        check("rst_src_state", CW'(dbg_src), CW'(0));
        @(posedge sink_clk);
        #1 reset = 1'b0;
        @(negedge sink_clk);
        check("ready_before_edge", CW'(bus.sink_ready), CW'(0));
        @(posedge sink_clk);
        @(negedge sink_clk);
        check("ready_after_rst", CW'(bus.sink_ready), CW'(1));

        for (int v = 0; v < 4; v++) begin
            clear_counts();
            push_run(vecs[v].base);
            wait_ready({vecs[v].name, "_ready_in"});
            send_run(vecs[v].base, 1'b1);
            for (int e = 0; e < vecs[v].extra; e++) send_entry(vecs[v].base + WIDTH'(32 + e), 1'b0, 1'b0);
            if (vecs[v].extra > 0) begin
                @(negedge sink_clk);
                check({vecs[v].name, "_ready_done"}, CW'(bus.sink_ready), CW'(0));
            end
            wait_ready({vecs[v].name, "_ready_back"});
            wait_burst(LENGTH);
            check({vecs[v].name, "_errors"}, CW'(err_cnt), CW'(vecs[v].exp_err));
            check({vecs[v].name, "_starts"}, CW'(start_cnt), CW'(1));
            check_out(vecs[v].name);
        end

        // Reset mid-run discards the partial run.
        clear_counts();
        for (int j = 0; j < 20; j++) send_entry(WIDTH'(50 + j), (j % LENGTH) == 0, (j % LENGTH) == LENGTH - 1);
        reset = 1'b1;
        repeat (6) @(posedge sink_clk);
        @(negedge sink_clk);
        check("s5_rst_ready", CW'(bus.sink_ready), CW'(0));
        check("s5_rst_snk_state", CW'(dbg_snk), CW'(0));
        check("s5_rst_src_state", CW'(dbg_src), CW'(0));
        @(posedge sink_clk);
        #1 reset = 1'b0;
        @(posedge sink_clk);
        @(negedge sink_clk);
        check("s5_ready_after", CW'(bus.sink_ready), CW'(1));
        repeat (40) @(negedge source_clk);
        check("s5_no_start", CW'(start_cnt), CW'(0));
        check("s5_no_output", CW'(cap_q.size()), CW'(0));
        push_run(16'd100);
        send_run(16'd100, 1'b1);
        wait_ready("s5_ready_back");
        wait_burst(LENGTH);
        check("s5_errors", CW'(err_cnt), CW'(0));
        check("s5_starts", CW'(start_cnt), CW'(1));
        check_out("s5_run");

        // Second run starts on the first cycle sink_ready is back.
        clear_counts();
        push_run(16'd200);
        push_run(16'd300);
        send_run(16'd200, 1'b1);
        wait_ready("s6_ready_a");
        send_run(16'd300, 1'b1);
        wait_ready("s6_ready_b");
        wait_burst(2 * LENGTH);
        check("s6_errors", CW'(err_cnt), CW'(0));
        check("s6_starts", CW'(start_cnt), CW'(2));
        check_out("s6_runs");

`ifdef OUTPUT_BUFFER_FRAMING_EN
        clear_counts();
        push_run(16'd0);
        for (int k = 0; k < LENGTH; k++) send_entry(WIDTH'(900 + k), k == 0, k == LENGTH - 1);
        for (int k = 0; k < 3; k++) send_entry(WIDTH'(908 + k), k == 0, 1'b0);
        send_run(16'd0, 1'b1);
        wait_ready("s3_ready_back");
        wait_burst(LENGTH);
        check("s3_errors", CW'(err_cnt), CW'(1));
        check("s3_starts", CW'(start_cnt), CW'(1));
        check_out("s3_run");

        clear_counts();
        for (int k = 0; k < 5; k++) send_entry(WIDTH'(700 + k), k == 0, 1'b0);
        send_entry(16'd705, 1'b0, 1'b1);
        repeat (3) @(negedge sink_clk);
        check("s4_errors", CW'(err_cnt), CW'(1));
        check("s4_snk_state", CW'(dbg_snk), CW'(0));
        check("s4_ready", CW'(bus.sink_ready), CW'(1));
        repeat (40) @(negedge source_clk);
        check("s4_no_start", CW'(start_cnt), CW'(0));
        check("s4_no_output", CW'(cap_q.size()), CW'(0));
`else
        clear_counts();
        push_run(16'd40);
        send_run(16'd40, 1'b0);
        wait_ready("count_ready_back");
        wait_burst(LENGTH);
        check("count_errors", CW'(err_cnt), CW'(0));
        check("count_starts", CW'(start_cnt), CW'(1));
        check_out("count_run");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1);
    end
endmodule
